// File: rtl/rst_seq.sv
// rst_seq: staggered multi-channel reset release followed by a bounded,
// pausable run window. Hard reset is i_rst (synchronous, active-low);
// i_soft_rst reruns the whole sequence from ASSERT.
module rst_seq #(
   parameter int NUM_CH      = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int STAGGER     = 1,
   parameter int RUN_CYCLES  = 100,
   parameter int CNT_W       = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_soft_rst,
   input  logic              i_hold,
   output logic [NUM_CH-1:0] o_rst,
   output logic              o_running,
   output logic              o_done,
   output logic [CNT_W-1:0]  o_cycle
);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]  HOLD_C   = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0]  STAG_C   = CNT_W'(STAGGER);
   localparam logic [CNT_W-1:0]  RUN_C    = CNT_W'(RUN_CYCLES);
   localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [NUM_CH-1:0] ALL_REL  = '1;
   localparam logic [NUM_CH-1:0] CH0      = NUM_CH'(1);
   // With a single channel or no stagger every channel leaves reset together.
   localparam bit                INSTANT  = (NUM_CH == 1) || (STAGGER == 0);

   function automatic longint max3(input longint a, input longint b, input longint c);
      longint m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   localparam longint NEED   = max3(longint'(HOLD_CYCLES),
                                    longint'(NUM_CH - 1) * longint'(STAGGER),
                                    longint'(RUN_CYCLES));
   localparam bit     CNT_OK = (CNT_W >= 62) || ((longint'(1) << CNT_W) > NEED);

   // Reject parameter sets the counters cannot represent.
   generate
      if (NUM_CH < 1 || HOLD_CYCLES < 1 || STAGGER < 0 || RUN_CYCLES < 0 ||
          CNT_W < 1 || !CNT_OK) begin : g_param_err
         $fatal(1, "rst_seq: illegal parameter combination");
      end
   endgenerate

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]    stag_cnt_q, stag_cnt_d;
   logic [CNT_W-1:0]    cycle_q, cycle_d;
   logic [NUM_CH-1:0]   rst_q, rst_d;
   logic                running_q, running_d;
   logic                done_q, done_d;

   // Next-state and next-output logic; soft reset overrides every transition.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      stag_cnt_d = stag_cnt_q;
      cycle_d    = cycle_q;
      rst_d      = rst_q;
      running_d  = running_q;
      done_d     = done_q;

      if (i_soft_rst) begin
         state_d    = ST_ASSERT;
         hold_cnt_d = '0;
         stag_cnt_d = '0;
         cycle_d    = '0;
         rst_d      = '0;
         running_d  = 1'b0;
         done_d     = 1'b0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if ((hold_cnt_q + ONE_C) == HOLD_C) begin
                  hold_cnt_d = '0;
                  stag_cnt_d = '0;
                  if (INSTANT) begin
                     rst_d     = ALL_REL;
                     running_d = 1'b1;
                     state_d   = ST_RUN;
                  end else begin
                     rst_d     = CH0;
                     state_d   = ST_RELEASE;
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + ONE_C;
               end
            end
            ST_RELEASE: begin
               if ((stag_cnt_q + ONE_C) == STAG_C) begin
                  stag_cnt_d = '0;
                  // Release the next channel in index order.
                  rst_d      = (rst_q << 1) | CH0;
                  if (&rst_d) begin
                     running_d = 1'b1;
                     state_d   = ST_RUN;
                  end
               end else begin
                  stag_cnt_d = stag_cnt_q + ONE_C;
               end
            end
            ST_RUN: begin
               if (!i_hold) begin
                  if (RUN_CYCLES == 0) begin
                     // Unbounded window: saturate rather than wrap.
                     if (cycle_q != CNT_MAX) cycle_d = cycle_q + ONE_C;
                  end else begin
                     cycle_d = cycle_q + ONE_C;
                     if (cycle_d == RUN_C) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        running_d = 1'b0;
                     end
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_ASSERT;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low hard reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q    <= ST_ASSERT;
         hold_cnt_q <= '0;
         stag_cnt_q <= '0;
         cycle_q    <= '0;
         rst_q      <= '0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         stag_cnt_q <= stag_cnt_d;
         cycle_q    <= cycle_d;
         rst_q      <= rst_d;
         running_q  <= running_d;
         done_q     <= done_d;
      end
   end

   assign o_rst     = rst_q;
   assign o_running = running_q;
   assign o_done    = done_q;
   assign o_cycle   = cycle_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: three rst_seq instances (default, wide/no-stagger, unbounded
// 4-bit counter) driven by the same inputs and checked every edge against a
// timeline model: edges elapsed since the sequence (re)started.
module tb_rst_seq;

   logic clk = 1'b0;
   logic i_rst = 1'b0;
   logic i_soft_rst = 1'b0;
   logic i_hold = 1'b0;

   logic [3:0]  o_rst_a;
   logic        o_running_a, o_done_a;
   logic [15:0] o_cycle_a;
   logic [7:0]  o_rst_b;
   logic        o_running_b, o_done_b;
   logic [15:0] o_cycle_b;
   logic [3:0]  o_rst_c;
   logic        o_running_c, o_done_c;
   logic [3:0]  o_cycle_c;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rst_seq dut_a (
      .i_clk(clk), .i_rst(i_rst), .i_soft_rst(i_soft_rst), .i_hold(i_hold),
      .o_rst(o_rst_a), .o_running(o_running_a), .o_done(o_done_a), .o_cycle(o_cycle_a)
   );

   rst_seq #(.NUM_CH(8), .HOLD_CYCLES(3), .STAGGER(0), .RUN_CYCLES(100), .CNT_W(16)) dut_b (
      .i_clk(clk), .i_rst(i_rst), .i_soft_rst(i_soft_rst), .i_hold(i_hold),
      .o_rst(o_rst_b), .o_running(o_running_b), .o_done(o_done_b), .o_cycle(o_cycle_b)
   );

   rst_seq #(.NUM_CH(4), .HOLD_CYCLES(2), .STAGGER(1), .RUN_CYCLES(0), .CNT_W(4)) dut_c (
      .i_clk(clk), .i_rst(i_rst), .i_soft_rst(i_soft_rst), .i_hold(i_hold),
      .o_rst(o_rst_c), .o_running(o_running_c), .o_done(o_done_c), .o_cycle(o_cycle_c)
   );

   typedef struct {
      int since;   // edges with i_rst high since last hard/soft reset
      int cyc;     // run cycles counted
      bit done;
   } mdl_t;

   mdl_t ma, mb, mc;

   // One clock edge of the reference timeline.
   function automatic mdl_t step(mdl_t m, bit r, bit s, bit h,
                                 int hold_c, int nch, int stg, int run_c, int cmax);
      int relt;
      relt = hold_c + (nch - 1) * stg;
      if (!r || s) begin
         m.since = 0;
         m.cyc   = 0;
         m.done  = 1'b0;
      end else begin
         if (m.since >= relt && !m.done && !h) begin
            if (run_c == 0) begin
               if (m.cyc < cmax) m.cyc++;
            end else begin
               m.cyc++;
               if (m.cyc == run_c) m.done = 1'b1;
            end
         end
         if (m.since < 1000000) m.since++;
      end
      return m;
   endfunction

   function automatic logic [63:0] exp_rst(mdl_t m, int hold_c, int nch, int stg);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < nch; k++)
         if (m.since >= hold_c + k * stg) v[k] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_inst(input string nm, input mdl_t m, input int hold_c, input int nch,
                           input int stg, input logic [63:0] rst, input logic run,
                           input logic done, input logic [63:0] cyc);
      int relt;
      relt = hold_c + (nch - 1) * stg;
      chk({nm, ".rst"},     rst,  exp_rst(m, hold_c, nch, stg));
      chk({nm, ".running"}, 64'(run), 64'((m.since >= relt) && !m.done));
      chk({nm, ".done"},    64'(done), 64'(m.done));
      chk({nm, ".cycle"},   cyc,  64'(m.cyc));
   endtask

   // Drive inputs, take one edge, advance models, check all instances #1 later.
   task automatic tick(input bit r, input bit s, input bit h);
      i_rst      = r;
      i_soft_rst = s;
      i_hold     = h;
      @(posedge clk);
      ma = step(ma, r, s, h, 2, 4, 1, 100, 65535);
      mb = step(mb, r, s, h, 3, 8, 0, 100, 65535);
      mc = step(mc, r, s, h, 2, 4, 1, 0, 15);
      #1;
      chk_inst("A", ma, 2, 4, 1, 64'(o_rst_a), o_running_a, o_done_a, 64'(o_cycle_a));
      chk_inst("B", mb, 3, 8, 0, 64'(o_rst_b), o_running_b, o_done_b, 64'(o_cycle_b));
      chk_inst("C", mc, 2, 4, 1, 64'(o_rst_c), o_running_c, o_done_c, 64'(o_cycle_c));
   endtask

   initial begin
      ma = '{0, 0, 1'b0};
      mb = '{0, 0, 1'b0};
      mc = '{0, 0, 1'b0};

      // Hard reset for two edges.
      tick(0, 0, 0);
      tick(0, 0, 0);
      chk("A.rst_reset", 64'(o_rst_a), 64'h0);
      chk("A.cycle_reset", 64'(o_cycle_a), 64'h0);

      // Full default sequence out to E200.
      for (int e = 1; e <= 200; e++) begin
         tick(1, 0, 0);
         if (e == 1) chk("A.rst_E1", 64'(o_rst_a), 64'h0);
         if (e == 2) chk("A.rst_E2", 64'(o_rst_a), 64'h1);
         if (e == 2) chk("B.rst_E2", 64'(o_rst_b), 64'h00);
         if (e == 3) chk("A.rst_E3", 64'(o_rst_a), 64'h3);
         if (e == 3) chk("B.rst_E3", 64'(o_rst_b), 64'hFF);
         if (e == 3) chk("B.running_E3", 64'(o_running_b), 64'h1);
         if (e == 4) chk("A.rst_E4", 64'(o_rst_a), 64'h7);
         if (e == 5) chk("A.running_E5", 64'(o_running_a), 64'h1);
         if (e == 6) chk("A.cycle_E6", 64'(o_cycle_a), 64'd1);
         if (e == 104) chk("A.done_E104", 64'(o_done_a), 64'h0);
         if (e == 105) chk("A.done_E105", 64'(o_done_a), 64'h1);
         if (e == 105) chk("A.cycle_E105", 64'(o_cycle_a), 64'd100);
      end
      chk("A.cycle_E200", 64'(o_cycle_a), 64'd100);
      chk("C.cycle_sat", 64'(o_cycle_c), 64'd15);
      chk("C.done_never", 64'(o_done_c), 64'h0);

      // Hold for 10 edges starting at cycle 20.
      tick(0, 0, 0);
      for (int e = 1; e <= 25; e++) tick(1, 0, 0);
      for (int e = 0; e < 10; e++) begin
         tick(1, 0, 1);
         chk("A.cycle_held", 64'(o_cycle_a), 64'd20);
      end
      for (int e = 36; e <= 120; e++) begin
         tick(1, 0, 0);
         if (e == 114) chk("A.done_E114", 64'(o_done_a), 64'h0);
         if (e == 115) chk("A.done_E115", 64'(o_done_a), 64'h1);
      end

      // Soft reset pulse at cycle 50, then full rerun.
      tick(0, 0, 0);
      for (int e = 1; e <= 55; e++) tick(1, 0, 0);
      chk("A.cycle_50", 64'(o_cycle_a), 64'd50);
      tick(1, 1, 0);
      chk("A.rst_soft", 64'(o_rst_a), 64'h0);
      chk("A.cycle_soft", 64'(o_cycle_a), 64'h0);
      for (int e = 1; e <= 110; e++) tick(1, 0, 0);

      // Hard reset mid-release.
      tick(0, 0, 0);
      for (int e = 1; e <= 3; e++) tick(1, 0, 0);
      chk("A.rst_mid", 64'(o_rst_a), 64'h3);
      tick(0, 0, 0);
      chk("A.rst_midrst", 64'(o_rst_a), 64'h0);
      for (int e = 1; e <= 10; e++) tick(1, 0, 0);

      // Soft reset on the edge that would have completed the run window.
      tick(0, 0, 0);
      for (int e = 1; e <= 104; e++) tick(1, 0, 0);
      chk("A.cycle_99", 64'(o_cycle_a), 64'd99);
      tick(1, 1, 0);
      chk("A.done_soft_vs_done", 64'(o_done_a), 64'h0);
      for (int e = 0; e < 8; e++) tick(1, 0, 0);

      // Soft reset held high keeps everything in ASSERT.
      for (int e = 0; e < 6; e++) tick(1, 1, 0);
      chk("A.rst_soft_held", 64'(o_rst_a), 64'h0);

      // Soft reset and hard reset on the same edge.
      for (int e = 0; e < 30; e++) tick(1, 0, 0);
      tick(0, 1, 0);
      chk("C.cycle_both", 64'(o_cycle_c), 64'h0);

      // Randomised traffic.
      for (int n = 0; n < 2000; n++) begin
         tick(($urandom_range(0, 399) != 0),
              ($urandom_range(0, 299) == 0),
              ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
